// File: rtl/fusion_pkg.sv
// Shared constants, FSM state type and bus-slicing helper for the
// fusion weight generator and its serial divider.
package fusion_pkg;

  localparam int NCH  = 6;
  localparam int W    = 16;
  localparam int FRAC = 15;
  localparam int CH_W = $clog2(NCH);

  localparam logic [W-1:0] Q_ONE_SAT = 16'd32767;
  localparam logic [W-1:0] Q_HALF    = 16'd16384;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    DIV,
    STORE,
    DONE
  } state_t;

  function automatic logic [W-1:0] ch_slice(input logic [NCH*W-1:0] bus,
                                            input logic [CH_W-1:0]  k);
    return bus[k*W +: W];
  endfunction

endpackage

// File: rtl/frac_divider.sv
// Serial restoring fractional divider: Q = floor(num * 2^FRAC / den), one
// quotient bit per cycle, MSB first. Requires num < den.
module frac_divider
  import fusion_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [W-1:0]    i_num,
  input  logic [W:0]      i_den,
  output logic [FRAC-1:0] o_q,
  output logic            o_last,
  output logic            o_q_valid
);

  localparam logic [3:0] LAST_CNT = 4'(FRAC - 1);

  logic [W:0]      r_rem;
  logic [W:0]      r_den;
  logic [FRAC-1:0] r_q;
  logic [3:0]      r_cnt;
  logic            r_active;
  logic            r_q_valid;

  logic [W+1:0]    w_rem2;
  logic            w_ge;
  logic [W+1:0]    w_rem_nxt;

  // Remainder stays below den, so the doubled value fits in W+2 bits.
  assign w_rem2    = {r_rem, 1'b0};
  assign w_ge      = (w_rem2 >= {1'b0, r_den});
  assign w_rem_nxt = w_ge ? (w_rem2 - {1'b0, r_den}) : w_rem2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_active  <= 1'b0;
      r_cnt     <= '0;
      r_q_valid <= 1'b0;
    end else begin
      r_q_valid <= 1'b0;
      if (i_load) begin
        r_active <= 1'b1;
        r_cnt    <= '0;
      end else if (r_active) begin
        r_cnt <= r_cnt + 4'd1;
        if (r_cnt == LAST_CNT) begin
          r_active  <= 1'b0;
          r_q_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_load) begin
      r_rem <= {1'b0, i_num};
      r_den <= i_den;
      r_q   <= '0;
    end else if (r_active) begin
      r_rem <= w_rem_nxt[W:0];
      r_q   <= {r_q[FRAC-2:0], w_ge};
    end
  end

  assign o_q       = r_q;
  assign o_last    = r_active && (r_cnt == LAST_CNT);
  assign o_q_valid = r_q_valid;

endmodule

// File: rtl/fusion_weight_gen.sv
// Computes per-channel fusion weights w1 = P2/(P1+P2), w2 = P1/(P1+P2) in Q1.15
// with one shared serial divider, presenting all channels together on done.
module fusion_weight_gen
  import fusion_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [NCH*W-1:0] p1_bus,
  input  logic [NCH*W-1:0] p2_bus,
  output logic [NCH*W-1:0] w1_bus,
  output logic [NCH*W-1:0] w2_bus,
  output logic             busy,
  output logic             done,
  output logic [NCH-1:0]   zero_sum,
  output logic [NCH-1:0]   neg_in
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NCH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CH_W-1:0]   r_ch;

  logic [NCH*W-1:0]  r_p1_cap;
  logic [NCH*W-1:0]  r_p2_cap;
  logic [NCH*W-1:0]  r_w1_bank;
  logic [NCH*W-1:0]  r_w2_bank;
  logic [NCH-1:0]    r_zs_bank;
  logic [NCH-1:0]    r_neg_bank;
  logic [W-1:0]      r_w1_res;
  logic [W-1:0]      r_w2_res;

  logic [NCH*W-1:0]  r_w1_out;
  logic [NCH*W-1:0]  r_w2_out;
  logic [NCH-1:0]    r_zs_out;
  logic [NCH-1:0]    r_neg_out;

  logic signed [W-1:0] w_p1_s;
  logic signed [W-1:0] w_p2_s;
  logic [W-1:0]      w_p1c;
  logic [W-1:0]      w_p2c;
  logic [W:0]        w_den;
  logic              w_zero;
  logic              w_p1z;
  logic              w_div_load;
  logic [FRAC-1:0]   w_q;
  logic              w_div_last;
  logic              w_q_valid;
  logic [W-1:0]      w_w1_fin;
  logic [W-1:0]      w_w2_fin;
  logic [NCH*W-1:0]  w_w1_bank_nxt;
  logic [NCH*W-1:0]  w_w2_bank_nxt;

  // w2 = 1.0 - w1; 1.0 is not representable in Q1.15, so clip to 32767.
  function automatic logic [W-1:0] sat_complement(input logic [FRAC-1:0] q);
    logic [W:0] diff;
    diff = 17'd32768 - {2'b00, q};
    if (diff > {1'b0, Q_ONE_SAT}) return Q_ONE_SAT;
    return diff[W-1:0];
  endfunction

  assign w_p1_s = ch_slice(r_p1_cap, r_ch);
  assign w_p2_s = ch_slice(r_p2_cap, r_ch);
  assign w_p1c  = w_p1_s[W-1] ? '0 : w_p1_s;
  assign w_p2c  = w_p2_s[W-1] ? '0 : w_p2_s;
  assign w_den  = {1'b0, w_p1c} + {1'b0, w_p2c};
  assign w_zero = (w_den == '0);
  assign w_p1z  = (w_p1c == '0);

  assign w_div_load = (r_state == LOAD) && !w_zero && !w_p1z;

  frac_divider u_div (
    .clk       (clk),
    .rst       (rst),
    .i_load    (w_div_load),
    .i_num     (w_p2c),
    .i_den     (w_den),
    .o_q       (w_q),
    .o_last    (w_div_last),
    .o_q_valid (w_q_valid)
  );

  // q_valid only pulses in STORE after a real division; otherwise use the
  // degenerate-case values latched in LOAD.
  assign w_w1_fin = w_q_valid ? {1'b0, w_q} : r_w1_res;
  assign w_w2_fin = w_q_valid ? sat_complement(w_q) : r_w2_res;

  always_comb begin
    w_w1_bank_nxt = r_w1_bank;
    w_w2_bank_nxt = r_w2_bank;
    w_w1_bank_nxt[r_ch*W +: W] = w_w1_fin;
    w_w2_bank_nxt[r_ch*W +: W] = w_w2_fin;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = (w_zero || w_p1z) ? STORE : DIV;
      DIV:     if (w_div_last) w_state_nxt = STORE;
      STORE:   w_state_nxt = (r_ch == LAST_CH) ? DONE : LOAD;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs load on the edge into DONE so they are fresh while done is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_w1_out  <= '0;
      r_w2_out  <= '0;
      r_zs_out  <= '0;
      r_neg_out <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == IDLE) && start) begin
        r_ch <= '0;
      end else if ((r_state == STORE) && (r_ch != LAST_CH)) begin
        r_ch <= r_ch + 1'b1;
      end
      if ((r_state == STORE) && (r_ch == LAST_CH)) begin
        r_w1_out  <= w_w1_bank_nxt;
        r_w2_out  <= w_w2_bank_nxt;
        r_zs_out  <= r_zs_bank;
        r_neg_out <= r_neg_bank;
      end
    end
  end

  always_ff @(posedge clk) begin
    if ((r_state == IDLE) && start) begin
      r_p1_cap <= p1_bus;
      r_p2_cap <= p2_bus;
    end
    if (r_state == LOAD) begin
      r_zs_bank[r_ch]  <= w_zero;
      r_neg_bank[r_ch] <= w_p1_s[W-1] | w_p2_s[W-1];
      r_w1_res         <= w_zero ? Q_HALF : Q_ONE_SAT;
      r_w2_res         <= w_zero ? Q_HALF : '0;
    end
    if (r_state == STORE) begin
      r_w1_bank <= w_w1_bank_nxt;
      r_w2_bank <= w_w2_bank_nxt;
    end
  end

  assign w1_bus   = r_w1_out;
  assign w2_bus   = r_w2_out;
  assign zero_sum = r_zs_out;
  assign neg_in   = r_neg_out;
  assign busy     = (r_state == LOAD) || (r_state == DIV) || (r_state == STORE);
  assign done     = (r_state == DONE);

endmodule

// File: tb/tb_fusion_weight_gen.sv
// Directed bench for fusion_weight_gen: expected weight sets are queued by an
// arithmetic reference model and popped when the DUT raises done.
module tb_fusion_weight_gen;
  import fusion_pkg::*;

  typedef struct {
    logic [NCH*W-1:0] w1;
    logic [NCH*W-1:0] w2;
    logic [NCH-1:0]   zs;
    logic [NCH-1:0]   neg;
    int               lat;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [NCH*W-1:0] p1_bus;
  logic [NCH*W-1:0] p2_bus;
  logic [NCH*W-1:0] w1_bus;
  logic [NCH*W-1:0] w2_bus;
  logic             busy;
  logic             done;
  logic [NCH-1:0]   zero_sum;
  logic [NCH-1:0]   neg_in;

  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  fusion_weight_gen dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .p1_bus   (p1_bus),
    .p2_bus   (p2_bus),
    .w1_bus   (w1_bus),
    .w2_bus   (w2_bus),
    .busy     (busy),
    .done     (done),
    .zero_sum (zero_sum),
    .neg_in   (neg_in)
  );

  task automatic chk(input string tag, input logic [NCH*W-1:0] obs, input logic [NCH*W-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [NCH*W-1:0] a_bus, input logic [NCH*W-1:0] b_bus);
    exp_t e;
    e.w1 = '0; e.w2 = '0; e.zs = '0; e.neg = '0; e.lat = 1;
    for (int k = 0; k < NCH; k++) begin
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb2;
      int a, b, d, q, x1, x2;
      sa = a_bus[k*W +: W];
      sb2 = b_bus[k*W +: W];
      a = sa;
      b = sb2;
      e.neg[k] = (a < 0) || (b < 0);
      if (a < 0) a = 0;
      if (b < 0) b = 0;
      d = a + b;
      e.zs[k] = (d == 0);
      if (d == 0) begin
        x1 = 16384; x2 = 16384; e.lat += 2;
      end else if (a == 0) begin
        x1 = 32767; x2 = 0; e.lat += 2;
      end else begin
        q = (b * 32768) / d;
        x1 = q;
        x2 = 32768 - q;
        if (x2 > 32767) x2 = 32767;
        e.lat += 17;
      end
      e.w1[k*W +: W] = x1[W-1:0];
      e.w2[k*W +: W] = x2[W-1:0];
    end
    return e;
  endfunction

  function automatic logic [NCH*W-1:0] pack(input int v0, input int v1, input int v2,
                                            input int v3, input int v4, input int v5);
    logic [NCH*W-1:0] b;
    b[0*W +: W] = v0[W-1:0]; b[1*W +: W] = v1[W-1:0]; b[2*W +: W] = v2[W-1:0];
    b[3*W +: W] = v3[W-1:0]; b[4*W +: W] = v4[W-1:0]; b[5*W +: W] = v5[W-1:0];
    return b;
  endfunction

  // One computation: push expectation, start, scramble inputs, optionally
  // poke start while busy, then pop and compare at done.
  task automatic run(input string name, input logic [NCH*W-1:0] a, input logic [NCH*W-1:0] b,
                     input bit poke_busy, output int lat);
    exp_t e;
    bit   got;
    bit   busy_ok;
    sb.push_back(model(a, b));
    @(negedge clk);
    p1_bus = a;
    p2_bus = b;
    start  = 1'b1;
    got = 1'b0; busy_ok = 1'b1; lat = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (c == 1) begin
        start  = 1'b0;
        p1_bus = {$urandom, $urandom, $urandom};
        p2_bus = {$urandom, $urandom, $urandom};
      end
      if (poke_busy && c == 50) start = 1'b1;
      if (poke_busy && c == 51) start = 1'b0;
      if (done) begin
        got = 1'b1;
        lat = c;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
    chk({name, " done_seen"}, NCH*W'(got), NCH*W'(1));
    e = sb.pop_front();
    if (got) begin
      chk({name, " latency"}, NCH*W'(lat), NCH*W'(e.lat));
      chk({name, " busy_during"}, NCH*W'(busy_ok), NCH*W'(1));
      chk({name, " busy_at_done"}, NCH*W'(busy), NCH*W'(0));
      chk({name, " w1"}, w1_bus, e.w1);
      chk({name, " w2"}, w2_bus, e.w2);
      chk({name, " zero_sum"}, NCH*W'(zero_sum), NCH*W'(e.zs));
      chk({name, " neg_in"}, NCH*W'(neg_in), NCH*W'(e.neg));
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({name, " start_in_done_ignored"}, NCH*W'({busy, done}), NCH*W'(0));
      chk({name, " w1_hold"}, w1_bus, e.w1);
    end
  endtask

  initial begin
    logic [NCH*W-1:0] a, b, all100;
    int   lat;
    bit   saw;

    rst = 1'b1; start = 1'b0; p1_bus = '0; p2_bus = '0;
    repeat (3) @(negedge clk);
    chk("rst w1", w1_bus, '0);
    chk("rst w2", w2_bus, '0);
    chk("rst flags", NCH*W'({zero_sum, neg_in}), NCH*W'(0));
    chk("rst busy_done", NCH*W'({busy, done}), NCH*W'(0));
    rst = 1'b0;

    // Equal covariances everywhere, with a start poke mid-run.
    all100 = pack(100, 100, 100, 100, 100, 100);
    run("equal", all100, all100, 1'b1, lat);
    chk("equal lat103", NCH*W'(lat), NCH*W'(103));
    chk("equal w1_ch0", NCH*W'(w1_bus[0*W +: W]), NCH*W'(16384));

    // Mixed ratios, degenerate and negative channels.
    a = pack(1, 3, 0, 0, -5, 32767);
    b = pack(3, 1, 50, 0, 10, 1);
    run("mixed", a, b, 1'b0, lat);
    chk("mixed w1_ch0", NCH*W'(w1_bus[0*W +: W]), NCH*W'(24576));
    chk("mixed w2_ch0", NCH*W'(w2_bus[0*W +: W]), NCH*W'(8192));
    chk("mixed w1_ch1", NCH*W'(w1_bus[1*W +: W]), NCH*W'(8192));
    chk("mixed w1_ch2", NCH*W'(w1_bus[2*W +: W]), NCH*W'(32767));
    chk("mixed w2_ch3", NCH*W'(w2_bus[3*W +: W]), NCH*W'(16384));
    chk("mixed w2_ch4", NCH*W'(w2_bus[4*W +: W]), NCH*W'(0));
    chk("mixed w1_ch5", NCH*W'(w1_bus[5*W +: W]), NCH*W'(1));
    chk("mixed w2_ch5", NCH*W'(w2_bus[5*W +: W]), NCH*W'(32767));
    chk("mixed zs", NCH*W'(zero_sum), NCH*W'(6'b001000));
    chk("mixed neg", NCH*W'(neg_in), NCH*W'(6'b010000));

    // Two degenerate channels save 30 cycles.
    a = pack(100, 100, 0, 0, 100, 100);
    b = pack(100, 100, 50, 0, 100, 100);
    run("degen2", a, b, 1'b0, lat);
    chk("degen2 lat73", NCH*W'(lat), NCH*W'(73));

    run("allzero", '0, '0, 1'b0, lat);
    chk("allzero lat13", NCH*W'(lat), NCH*W'(13));

    // Reset while ch2 is dividing aborts the run.
    @(negedge clk);
    p1_bus = all100; p2_bus = all100; start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort w1", w1_bus, '0);
    chk("abort w2", w2_bus, '0);
    chk("abort flags", NCH*W'({zero_sum, neg_in}), NCH*W'(0));
    chk("abort busy_done", NCH*W'({busy, done}), NCH*W'(0));
    saw = 1'b0;
    repeat (150) begin
      @(negedge clk);
      if (done || busy) saw = 1'b1;
    end
    chk("abort no_done", NCH*W'(saw), NCH*W'(0));

    run("fresh", all100, all100, 1'b1, lat);
    chk("fresh lat103", NCH*W'(lat), NCH*W'(103));

    for (int i = 0; i < 3; i++) begin
      run("random", {$urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom}, 1'b1, lat);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
